// File: rtl/obj_pkg.sv
// Shared types and constants for the OBJ row fetch stage.
package obj_pkg;

    localparam int unsigned SCREEN_W = 240;
    localparam int unsigned PPW_4BPP = 8;
    localparam int unsigned PPW_8BPP = 4;
    localparam int unsigned PIX_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_UNPACK,
        ST_DONE
    } fetch_state_t;

    typedef struct packed {
        logic [9:0] objname;
        logic       palettemode;
        logic [6:0] hsize;
        logic [5:0] row_y;
        logic       hflip;
        logic [8:0] screen_x;
        logic [3:0] pal_bank;
        logic [1:0] obj_pri;
    } obj_row_desc_t;

    // Index of the last pixel inside one VRAM word.
    function automatic logic [2:0] last_pix(input logic palettemode);
        return palettemode ? 3'(PPW_8BPP - 1) : 3'(PPW_4BPP - 1);
    endfunction

endpackage

// File: rtl/obj_pixel_unpacker.sv
// Holds the fetched VRAM word and selects one pixel (nibble or byte) from it.
module obj_pixel_unpacker
    import obj_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             capture,
    input  logic [DW-1:0]    rdata,
    input  logic [2:0]       idx,
    input  logic             hflip,
    input  logic             palettemode,
    input  logic [3:0]       pal_bank,
    output logic [PIX_W-1:0] pix_c,
    output logic             opaque_c
);

    logic [DW-1:0] word_q;
    logic [DW-1:0] word;
    logic [2:0]    nib_sel;
    logic [1:0]    byte_sel;
    logic [3:0]    nib;
    logic [7:0]    byt;

    // Captured word register; loaded on the VRAM ack cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            word_q <= '0;
        end else if (capture) begin
            word_q <= rdata;
        end
    end

    // On the ack cycle the first pixel comes straight from the read data.
    always_comb begin
        word     = capture ? rdata : word_q;
        nib_sel  = hflip ? (3'd7 - idx) : idx;
        byte_sel = hflip ? (2'd3 - idx[1:0]) : idx[1:0];
        nib      = word[{nib_sel, 2'b00} +: 4];
        byt      = word[{byte_sel, 3'b000} +: 8];
        if (palettemode) begin
            pix_c    = byt;
            opaque_c = |byt;
        end else begin
            pix_c    = {pal_bank, nib};
            opaque_c = |nib;
        end
    end

endmodule

// File: rtl/obj_row_fetcher.sv
// Fetches one sprite row from VRAM word by word and writes its pixels to the OBJ line buffer.
module obj_row_fetcher #(
    parameter int unsigned SCREEN_W = obj_pkg::SCREEN_W,
    parameter int unsigned VRAM_AW  = 15,
    parameter int unsigned VRAM_DW  = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [9:0]         objname,
    input  logic               palettemode,
    input  logic [6:0]         hsize,
    input  logic [5:0]         row_y,
    input  logic               hflip,
    input  logic [8:0]         screen_x,
    input  logic [3:0]         pal_bank,
    input  logic [1:0]         obj_pri,
    output logic [5:0]         au_x,
    output logic [5:0]         au_y,
    input  logic [VRAM_AW-1:0] au_addr,
    output logic               vram_req,
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic               vram_ack,
    input  logic [VRAM_DW-1:0] vram_rdata,
    output logic               lb_we,
    output logic [8:0]         lb_x,
    output logic [7:0]         lb_data,
    output logic [1:0]         lb_pri,
    output logic               busy,
    output logic               done
);

    import obj_pkg::fetch_state_t;
    import obj_pkg::ST_IDLE;
    import obj_pkg::ST_REQ;
    import obj_pkg::ST_UNPACK;
    import obj_pkg::ST_DONE;
    import obj_pkg::obj_row_desc_t;
    import obj_pkg::PPW_4BPP;
    import obj_pkg::PPW_8BPP;
    import obj_pkg::PIX_W;
    import obj_pkg::last_pix;

    fetch_state_t  state_q, state_d;
    obj_row_desc_t desc_q, desc_d;
    logic [5:0]    au_x_d;
    logic [3:0]    words_left_q, words_left_d;
    logic [2:0]    pix_q, pix_d;
    logic [8:0]    x_q, x_d;
    logic          vram_req_d, lb_we_d, busy_d, done_d;
    logic [8:0]    lb_x_d;
    logic [7:0]    lb_data_d;
    logic [1:0]    lb_pri_d;

    logic             capture;
    logic             emit;
    logic [2:0]       sel_idx;
    logic [PIX_W-1:0] pix_val;
    logic             pix_opaque;
    logic [6:0]       ppw_in;
    logic [4:0]       nwords_in;
    logic [5:0]       ppw_q;
    logic             unused_desc;

    assign ppw_in    = palettemode ? 7'(PPW_8BPP) : 7'(PPW_4BPP);
    assign nwords_in = palettemode ? hsize[6:2] : {1'b0, hsize[6:3]};
    assign ppw_q     = desc_q.palettemode ? 6'(PPW_8BPP) : 6'(PPW_4BPP);

    // Address is only presented while a read is outstanding.
    assign vram_addr = vram_req ? au_addr : '0;
    assign au_y      = desc_q.row_y;

    // Fields kept for completeness of the latched descriptor but consumed elsewhere.
    assign unused_desc = ^{desc_q.objname, desc_q.hsize, desc_q.screen_x};

    obj_pixel_unpacker #(
        .DW (VRAM_DW)
    ) u_unpacker (
        .clock       (clock),
        .reset_n     (reset_n),
        .capture     (capture),
        .rdata       (vram_rdata),
        .idx         (sel_idx),
        .hflip       (desc_q.hflip),
        .palettemode (desc_q.palettemode),
        .pal_bank    (desc_q.pal_bank),
        .pix_c       (pix_val),
        .opaque_c    (pix_opaque)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            desc_q       <= '0;
            au_x         <= '0;
            words_left_q <= '0;
            pix_q        <= '0;
            x_q          <= '0;
            vram_req     <= 1'b0;
            lb_we        <= 1'b0;
            lb_x         <= '0;
            lb_data      <= '0;
            lb_pri       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            desc_q       <= desc_d;
            au_x         <= au_x_d;
            words_left_q <= words_left_d;
            pix_q        <= pix_d;
            x_q          <= x_d;
            vram_req     <= vram_req_d;
            lb_we        <= lb_we_d;
            lb_x         <= lb_x_d;
            lb_data      <= lb_data_d;
            lb_pri       <= lb_pri_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

    // Next-state and next-output decode; outputs are set up one cycle ahead of the state they belong to.
    always_comb begin
        state_d      = state_q;
        desc_d       = desc_q;
        au_x_d       = au_x;
        words_left_d = words_left_q;
        pix_d        = pix_q;
        x_d          = x_q;
        vram_req_d   = 1'b0;
        lb_we_d      = 1'b0;
        lb_x_d       = lb_x;
        lb_data_d    = '0;
        lb_pri_d     = '0;
        busy_d       = 1'b1;
        done_d       = 1'b0;
        capture      = 1'b0;
        emit         = 1'b0;
        sel_idx      = pix_q + 3'd1;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    desc_d.objname     = objname;
                    desc_d.palettemode = palettemode;
                    desc_d.hsize       = hsize;
                    desc_d.row_y       = row_y;
                    desc_d.hflip       = hflip;
                    desc_d.screen_x    = screen_x;
                    desc_d.pal_bank    = pal_bank;
                    desc_d.obj_pri     = obj_pri;
                    au_x_d             = hflip ? 6'(hsize - ppw_in) : 6'd0;
                    words_left_d       = 4'(nwords_in - 5'd1);
                    x_d                = screen_x;
                    vram_req_d         = 1'b1;
                    busy_d             = 1'b1;
                    state_d            = ST_REQ;
                end
            end
            ST_REQ: begin
                vram_req_d = 1'b1;
                if (vram_ack) begin
                    capture    = 1'b1;
                    sel_idx    = 3'd0;
                    emit       = 1'b1;
                    pix_d      = 3'd0;
                    vram_req_d = 1'b0;
                    state_d    = ST_UNPACK;
                end
            end
            ST_UNPACK: begin
                if (pix_q == last_pix(desc_q.palettemode)) begin
                    if (words_left_q == 4'd0) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        words_left_d = words_left_q - 4'd1;
                        au_x_d       = desc_q.hflip ? (au_x - ppw_q) : (au_x + ppw_q);
                        vram_req_d   = 1'b1;
                        state_d      = ST_REQ;
                    end
                end else begin
                    emit  = 1'b1;
                    pix_d = pix_q + 3'd1;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        if (emit) begin
            lb_we_d   = pix_opaque && (32'(x_q) < SCREEN_W);
            lb_x_d    = x_q;
            lb_data_d = pix_val;
            lb_pri_d  = desc_q.obj_pri;
            x_d       = x_q + 9'd1;
        end
    end

endmodule

// File: tb/tb_obj_row_fetcher.sv
// Directed table-driven bench for obj_row_fetcher.
module tb_obj_row_fetcher;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  objname = '0;
    logic        palettemode = 1'b0;
    logic [6:0]  hsize = 7'd8;
    logic [5:0]  row_y = '0;
    logic        hflip = 1'b0;
    logic [8:0]  screen_x = '0;
    logic [3:0]  pal_bank = '0;
    logic [1:0]  obj_pri = '0;
    logic [5:0]  au_x;
    logic [5:0]  au_y;
    logic [14:0] au_addr;
    logic        vram_req;
    logic [14:0] vram_addr;
    logic        vram_ack = 1'b0;
    logic [31:0] vram_rdata = 32'hDEADBEEF;
    logic        lb_we;
    logic [8:0]  lb_x;
    logic [7:0]  lb_data;
    logic [1:0]  lb_pri;
    logic        busy;
    logic        done;

    // Stand-in for the combinational OBJ address unit.
    assign au_addr = {objname[4:0], au_y[3:0], au_x};

    obj_row_fetcher dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .objname     (objname),
        .palettemode (palettemode),
        .hsize       (hsize),
        .row_y       (row_y),
        .hflip       (hflip),
        .screen_x    (screen_x),
        .pal_bank    (pal_bank),
        .obj_pri     (obj_pri),
        .au_x        (au_x),
        .au_y        (au_y),
        .au_addr     (au_addr),
        .vram_req    (vram_req),
        .vram_addr   (vram_addr),
        .vram_ack    (vram_ack),
        .vram_rdata  (vram_rdata),
        .lb_we       (lb_we),
        .lb_x        (lb_x),
        .lb_data     (lb_data),
        .lb_pri      (lb_pri),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        pm;
        logic [6:0]  hs;
        logic [5:0]  ry;
        logic        hf;
        logic [8:0]  sx;
        logic [3:0]  bk;
        logic [1:0]  pr;
        logic [9:0]  on;
        int          delay;
        logic [31:0] w0;
        logic [31:0] w1;
        int          nreq;
        logic [5:0]  ax0;
        logic [5:0]  ax1;
        logic [8:0]  last_x;
        int          cycles;
    } vec_t;

    localparam int NV = 6;
    vec_t       vecs [NV];
    logic [8:0] ex_x [NV][16];
    logic [7:0] ex_d [NV][16];
    int         ex_n [NV];

    int n_chk  = 0;
    int n_pass = 0;

    // Observations from the last run_row call.
    logic [8:0] obs_x [64];
    logic [7:0] obs_d [64];
    logic [1:0] obs_p [64];
    logic [5:0] obs_ax [16];
    logic [5:0] obs_ay;
    int         obs_n, obs_nreq, obs_cycles;
    logic [8:0] obs_last_x;
    bit         obs_addr_ok, obs_timeout, obs_done_after, obs_busy_after;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic pm, input logic [6:0] hs, input logic [5:0] ry,
                                input logic hf, input logic [8:0] sx, input logic [3:0] bk,
                                input logic [1:0] pr, input logic [9:0] on, input int dl,
                                input logic [31:0] w0, input logic [31:0] w1, input int nreq,
                                input logic [5:0] ax0, input logic [5:0] ax1,
                                input logic [8:0] lx, input int cy);
        vec_t v;
        v.pm = pm; v.hs = hs; v.ry = ry; v.hf = hf; v.sx = sx; v.bk = bk; v.pr = pr;
        v.on = on; v.delay = dl; v.w0 = w0; v.w1 = w1; v.nreq = nreq;
        v.ax0 = ax0; v.ax1 = ax1; v.last_x = lx; v.cycles = cy;
        return v;
    endfunction

    task automatic add_wr(input int i, input logic [8:0] x, input logic [7:0] d);
        ex_x[i][ex_n[i]] = x;
        ex_d[i][ex_n[i]] = d;
        ex_n[i]++;
    endtask

    function automatic logic [49:0] outs();
        return {vram_req, vram_addr, lb_we, lb_x, lb_data, lb_pri, busy, done, au_x, au_y};
    endfunction

    // Drive one fetch, answer VRAM reads, scramble inputs and poke start while busy.
    task automatic run_row(input vec_t v);
        int cyc = 0, wc = 0, wt = 0, first_req = -1;
        bit fin = 0, in_req = 0;
        logic [14:0] req_addr = '0;
        obs_n = 0; obs_nreq = 0; obs_cycles = -1; obs_addr_ok = 1; obs_timeout = 0;
        obs_last_x = '0; obs_ay = '0;
        @(negedge clock);
        objname = v.on; palettemode = v.pm; hsize = v.hs; row_y = v.ry; hflip = v.hf;
        screen_x = v.sx; pal_bank = v.bk; obj_pri = v.pr; start = 1'b1;
        while (!fin) begin
            @(negedge clock);
            if (cyc == 0) begin
                palettemode = ~v.pm; hsize = 7'd64; row_y = ~v.ry; hflip = ~v.hf;
                screen_x = 9'h1AB; pal_bank = ~v.bk; obj_pri = ~v.pr;
            end
            start = (cyc == 3);
            vram_ack = 1'b0;
            vram_rdata = 32'hDEADBEEF;
            if (vram_req) begin
                if (!in_req) begin
                    in_req = 1; req_addr = vram_addr; wt = 0;
                    if (obs_nreq < 16) obs_ax[obs_nreq] = au_x;
                    if (obs_nreq == 0) obs_ay = au_y;
                    obs_nreq++;
                    if (first_req < 0) first_req = cyc;
                end
                if (vram_addr != req_addr || vram_addr != au_addr) obs_addr_ok = 0;
                if (wt == v.delay) begin
                    vram_ack = 1'b1;
                    vram_rdata = (wc == 0) ? v.w0 : v.w1;
                    wc++; in_req = 0;
                end else begin
                    wt++;
                end
            end
            if (lb_we) begin
                if (obs_n < 64) begin
                    obs_x[obs_n] = lb_x; obs_d[obs_n] = lb_data; obs_p[obs_n] = lb_pri;
                end
                obs_n++;
            end
            if (done) begin
                fin = 1; obs_cycles = cyc - first_req; obs_last_x = lb_x;
            end
            cyc++;
            if (cyc > 400) begin fin = 1; obs_timeout = 1; end
        end
        start = 1'b0;
        @(negedge clock);
        vram_ack = 1'b0;
        obs_done_after = done;
        obs_busy_after = busy;
    endtask

    task automatic check_vec(input string tag, input int i);
        vec_t v = vecs[i];
        chk({tag, "_timeout"}, obs_timeout, 0);
        chk({tag, "_nreq"}, obs_nreq, v.nreq);
        chk({tag, "_au_x0"}, obs_ax[0], v.ax0);
        if (v.nreq > 1) chk({tag, "_au_x1"}, obs_ax[1], v.ax1);
        chk({tag, "_au_y"}, obs_ay, v.ry);
        chk({tag, "_addr_stable"}, obs_addr_ok, 1);
        chk({tag, "_nwrites"}, obs_n, ex_n[i]);
        for (int j = 0; j < ex_n[i]; j++) begin
            if (j < obs_n) begin
                chk($sformatf("%s_w%0d_x", tag, j), obs_x[j], ex_x[i][j]);
                chk($sformatf("%s_w%0d_data", tag, j), obs_d[j], ex_d[i][j]);
                chk($sformatf("%s_w%0d_pri", tag, j), obs_p[j], v.pr);
            end
        end
        chk({tag, "_last_lb_x"}, obs_last_x, v.last_x);
        chk({tag, "_cycles"}, obs_cycles, v.cycles);
        chk({tag, "_done_pulse"}, obs_done_after, 0);
        chk({tag, "_busy_after"}, obs_busy_after, 0);
    endtask

    initial begin
        bit   found, quiet;
        vec_t h;

        // pm hs ry hf sx bank pri objname delay w0 w1 nreq ax0 ax1 last_x cycles
        vecs[0] = mk(1'b0, 7'd8,  6'd3, 1'b0, 9'd10,  4'h5, 2'd2, 10'h2A5, 0,
                     32'h87654321, 32'h0, 1, 6'd0, 6'd0, 9'd17, 9);
        vecs[1] = mk(1'b0, 7'd16, 6'd7, 1'b1, 9'd0,   4'h3, 2'd1, 10'h011, 0,
                     32'h87654321, 32'hFEDC0A98, 2, 6'd8, 6'd0, 9'd15, 18);
        vecs[2] = mk(1'b1, 7'd8,  6'd0, 1'b0, 9'd100, 4'hF, 2'd3, 10'h3FF, 0,
                     32'h00FF0201, 32'h04030000, 2, 6'd0, 6'd4, 9'd107, 10);
        vecs[3] = mk(1'b0, 7'd16, 6'd1, 1'b0, 9'd236, 4'h9, 2'd0, 10'h100, 5,
                     32'h87654321, 32'h87654321, 2, 6'd0, 6'd8, 9'd251, 28);
        vecs[4] = mk(1'b0, 7'd8,  6'd2, 1'b0, 9'd508, 4'h1, 2'd2, 10'h055, 0,
                     32'h87654321, 32'h0, 1, 6'd0, 6'd0, 9'd3, 9);
        vecs[5] = mk(1'b1, 7'd8,  6'd5, 1'b1, 9'd20,  4'h0, 2'd1, 10'h1C3, 2,
                     32'h44332211, 32'h00BB00AA, 2, 6'd4, 6'd0, 9'd27, 14);
        for (int i = 0; i < NV; i++) ex_n[i] = 0;
        for (int k = 0; k < 8; k++) add_wr(0, 9'(10 + k), 8'(8'h51 + k));
        for (int k = 0; k < 8; k++) add_wr(1, 9'(k), 8'(8'h38 - k));
        add_wr(1, 9'd8, 8'h3F);  add_wr(1, 9'd9, 8'h3E);  add_wr(1, 9'd10, 8'h3D);
        add_wr(1, 9'd11, 8'h3C); add_wr(1, 9'd13, 8'h3A); add_wr(1, 9'd14, 8'h39);
        add_wr(1, 9'd15, 8'h38);
        add_wr(2, 9'd100, 8'h01); add_wr(2, 9'd101, 8'h02); add_wr(2, 9'd102, 8'hFF);
        add_wr(2, 9'd106, 8'h03); add_wr(2, 9'd107, 8'h04);
        for (int k = 0; k < 4; k++) add_wr(3, 9'(236 + k), 8'(8'h91 + k));
        for (int k = 0; k < 4; k++) add_wr(4, 9'(k), 8'(8'h15 + k));
        add_wr(5, 9'd20, 8'h44); add_wr(5, 9'd21, 8'h33); add_wr(5, 9'd22, 8'h22);
        add_wr(5, 9'd23, 8'h11); add_wr(5, 9'd25, 8'hBB); add_wr(5, 9'd27, 8'hAA);

        // Power-up reset.
        repeat (3) @(negedge clock);
        chk("reset_outputs", outs(), 0);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_row(vecs[i]);
            check_vec($sformatf("v%0d", i), i);
        end

        // 64-px 4bpp row: 8 words, 72 cycles from first request to done.
        h = mk(1'b0, 7'd64, 6'd4, 1'b0, 9'd0, 4'h2, 2'd1, 10'h0A0, 0,
               32'h87654321, 32'h87654321, 8, 6'd0, 6'd8, 9'd63, 72);
        run_row(h);
        chk("w64_cycles", obs_cycles, 72);
        chk("w64_nreq", obs_nreq, 8);
        chk("w64_last_au_x", obs_ax[7], 56);
        chk("w64_nwrites", obs_n, 64);
        chk("w64_last_lb_x", obs_last_x, 63);

        // 64-px 8bpp mirrored row: au_x 60 down to 0 over 16 words.
        h = mk(1'b1, 7'd64, 6'd9, 1'b1, 9'd0, 4'h0, 2'd3, 10'h0C0, 0,
               32'h87654321, 32'h87654321, 16, 6'd60, 6'd56, 9'd63, 80);
        run_row(h);
        chk("b64_cycles", obs_cycles, 80);
        chk("b64_first_au_x", obs_ax[0], 60);
        chk("b64_last_au_x", obs_ax[15], 0);
        chk("b64_nwrites", obs_n, 64);

        // Reset asserted while unpacking.
        @(negedge clock);
        objname = 10'h155; palettemode = 1'b0; hsize = 7'd16; row_y = 6'd6; hflip = 1'b0;
        screen_x = 9'd50; pal_bank = 4'h7; obj_pri = 2'd3; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            vram_ack = vram_req;
            vram_rdata = 32'h87654321;
            @(negedge clock);
            if (lb_we) found = 1;
        end
        chk("rst_reached_unpack", found, 1);
        vram_ack = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        chk("rst_mid_outputs", outs(), 0);
        reset_n = 1'b1;
        vram_ack = 1'b1;
        quiet = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (lb_we || busy || vram_req) quiet = 0;
        end
        vram_ack = 1'b0;
        chk("rst_idle_quiet", quiet, 1);
        run_row(vecs[0]);
        check_vec("after_rst", 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/obj_row_fetcher.md
Name: obj_row_fetcher

Overview:
- Sequential OBJ pixel fetch stage; consumes the VRAM word address from the combinational OBJ address unit.
- For one sprite row on the current scanline it steps the in-sprite x coordinate across the sprite width, reads each VRAM word and unpacks it into per-pixel writes to the OBJ line buffer.
- Upstream: the OAM scan/evaluation stage supplies one sprite descriptor per start pulse. Downstream: VRAM read arbiter and OBJ line buffer.

Parameters:
SCREEN_W, 240, visible pixels; writes at lb_x >= SCREEN_W are suppressed
VRAM_AW, 15, VRAM word-address width
VRAM_DW, 32, VRAM read-data width (one word)

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle request to fetch one sprite row; honoured only in IDLE
objname  in  10  tile number, held by upstream for the whole fetch
palettemode  in  1  1 = 8bpp (4 px/word), 0 = 4bpp (8 px/word)
hsize  in  7  sprite width in pixels: 8, 16, 32 or 64
row_y  in  6  row within sprite (vertical flip already applied upstream)
hflip  in  1  mirror the row horizontally
screen_x  in  9  screen x of sprite's leftmost pixel, modulo 512
pal_bank  in  4  palette bank for 4bpp
obj_pri  in  2  priority passed to line buffer
au_x  out  6  in-sprite x given to address unit
au_y  out  6  in-sprite y given to address unit (= latched row_y)
au_addr  in  VRAM_AW  address returned combinationally by address unit
vram_req  out  1  read request
vram_addr  out  VRAM_AW  read address
vram_ack  in  1  read done; vram_rdata valid this cycle
vram_rdata  in  VRAM_DW  read data
lb_we  out  1  line-buffer write strobe
lb_x  out  9  line-buffer x
lb_data  out  8  palette index
lb_pri  out  2  priority
busy  out  1  high whenever not in IDLE
done  out  1  one-cycle pulse at end of row

Behaviour:
- Reset (reset_n=0 at a clock edge): state IDLE; every output 0. Applies mid-fetch too: vram_req drops at once, no further lb_we.
- States: IDLE, REQ, UNPACK, DONE.
- IDLE: when start=1, latch all descriptor inputs and go to REQ. start outside IDLE is ignored.
- Pixels per word (ppw): 8 if palettemode=0, 4 if 1. Word count = hsize/ppw: 1 to 8 (4bpp) or 2 to 16 (8bpp).
- au_x sequence, non-flipped: 0, ppw, 2*ppw, ...
- au_x sequence, hflip: hsize-ppw, hsize-2*ppw, ..., 0.
- REQ:
  - vram_req=1 and vram_addr=au_addr, both stable until vram_ack.
  - vram_ack is only sampled while vram_req=1.
  - On ack: capture vram_rdata, drop vram_req the next cycle, go to UNPACK.
- UNPACK: ppw cycles, one pixel per cycle.
  - Pixel order is low nibble/byte first; reversed when hflip=1.
  - 4bpp: lb_data={pal_bank, nibble}. 8bpp: lb_data=byte.
  - lb_x starts at latched screen_x, +1 every pixel across the whole row, wraps 511 -> 0.
  - lb_we=1 only if the pixel index is non-zero (transparent otherwise) and lb_x < SCREEN_W. lb_x advances either way.
  - After the last pixel: go to REQ if words remain, else DONE.
- DONE: done=1 for one cycle, then IDLE. busy falls in the same cycle done falls.
- Latency with zero-wait VRAM (ack in the first REQ cycle): per word 1 + ppw cycles. A 64-px 4bpp row takes 8*9 = 72 cycles from first REQ to DONE.
- Arithmetic: au_x is 6 bits and never exceeds hsize-ppw. lb_x is a 9-bit wrapping counter.

Decomposition:
- Shared package obj_pkg:
  - fetch state enum
  - PPW_4BPP=8, PPW_8BPP=4
  - SCREEN_W constant
  - packed struct obj_row_desc_t (objname, palettemode, hsize, row_y, hflip, screen_x, pal_bank, obj_pri)
- One natural sub-module: obj_pixel_unpacker. It holds the captured word and selects the nibble/byte from a pixel index and hflip. The FSM and counters stay in the top.
- The address unit is instantiated by the parent, not inside this block.

Test Plan:
- 4bpp, hsize=8, screen_x=10, hflip=0, ack immediate, rdata=0x87654321 -> one REQ; lb_we on x=10..17 with data {bank,1..8}; done 1 cycle after last write.
- 4bpp, hsize=16, hflip=1 -> au_x sequence 8 then 0; pixels within each word emitted in reverse nibble order; lb_x 0..15 contiguous.
- 8bpp, hsize=8, rdata words 0x00FF0201 and 0x04030000 -> au_x 0 then 4; writes at x+0=0x01, x+1=0x02, x+2=0xFF, x+6=0x03, x+7=0x04; zero bytes are not written.
- screen_x=236, 4bpp, hsize=16, all nibbles non-zero -> writes only at 236..239; lb_x continues 240..251 with lb_we=0.
- screen_x=508, hsize=8 -> lb_x 508..511, 0..3; writes only at 0..3.
- vram_ack delayed 5 cycles, start pulsed while busy, reset_n low during UNPACK -> vram_addr stable while waiting; the second start is ignored; after reset all outputs are 0 and a new start is accepted.
